// File: rtl/output_capture_misr.sv
// output_capture_misr
//   Samples a wide DUT output bus on qualified clock edges and compacts the
//   samples into a MISR signature. After NUM_SAMPLES qualified samples the
//   signature is offered on a valid/ready port.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a capture run (honoured only in IDLE)
//   y            DUT output bus being captured
//   y_valid      y holds a sample to compact this cycle
//   sig_data     final signature
//   sig_valid    sig_data valid
//   sig_ready    consumer accepts signature
//   busy         high while capturing or holding a signature
//   sample_count qualified samples compacted in the current run
module output_capture_misr #(
   parameter int                   Y_WIDTH     = 635,
   parameter int                   SIG_WIDTH   = 32,
   parameter int                   NUM_SAMPLES = 22,
   parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
   parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [Y_WIDTH-1:0]   y,
   input  logic                 y_valid,
   output logic [SIG_WIDTH-1:0] sig_data,
   output logic                 sig_valid,
   input  logic                 sig_ready,
   output logic                 busy,
   output logic [7:0]           sample_count
);

   localparam int         NCH   = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int         PADW  = NCH * SIG_WIDTH;
   localparam logic [7:0] N_END = 8'(NUM_SAMPLES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [SIG_WIDTH-1:0] misr_q, misr_d;
   logic [SIG_WIDTH-1:0] sig_data_q, sig_data_d;
   logic                 sig_valid_q, sig_valid_d;
   logic [7:0]           cnt_q, cnt_d;

   logic [PADW-1:0]      y_pad;
   logic [SIG_WIDTH-1:0] fold;
   logic [SIG_WIDTH-1:0] misr_step;
   logic [7:0]           cnt_inc;

   // Fold: XOR of SIG_WIDTH-bit chunks of y, top chunk zero-padded.
   always_comb begin
      y_pad              = '0;
      y_pad[Y_WIDTH-1:0] = y;
      fold               = '0;
      for (int c = 0; c < NCH; c++) begin
         fold = fold ^ y_pad[c*SIG_WIDTH +: SIG_WIDTH];
      end
   end

   assign misr_step = {misr_q[SIG_WIDTH-2:0], 1'b0}
                    ^ (misr_q[SIG_WIDTH-1] ? POLY : '0)
                    ^ fold;
   assign cnt_inc   = cnt_q + 8'd1;

   // misr_step is only selected when y_valid is high, so an undefined y
   // during gaps never reaches the MISR register.
   always_comb begin
      state_d     = state_q;
      misr_d      = misr_q;
      sig_data_d  = sig_data_q;
      sig_valid_d = sig_valid_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               misr_d  = SEED;
               cnt_d   = 8'd0;
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (y_valid) begin
               misr_d = misr_step;
               cnt_d  = cnt_inc;
               // Final sample: signature is published on the same edge
               // that registers the last MISR value.
               if (cnt_inc == N_END) begin
                  state_d     = S_DONE;
                  sig_data_d  = misr_step;
                  sig_valid_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (sig_ready) begin
               state_d     = S_IDLE;
               sig_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            sig_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         misr_q      <= '0;
         sig_data_q  <= '0;
         sig_valid_q <= 1'b0;
         cnt_q       <= 8'd0;
      end else begin
         state_q     <= state_d;
         misr_q      <= misr_d;
         sig_data_q  <= sig_data_d;
         sig_valid_q <= sig_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign sig_data     = sig_data_q;
   assign sig_valid    = sig_valid_q;
   assign busy         = (state_q != S_IDLE);
   assign sample_count = cnt_q;

endmodule

// File: tb/tb_output_capture_misr.sv
module tb_output_capture_misr;

   localparam int          YW   = 635;
   localparam logic [31:0] POLY = 32'h04C11DB7;
   localparam logic [31:0] SEED = 32'hFFFFFFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [YW-1:0] y = '0;
   logic          y_valid = 1'b0;
   logic          sig_ready = 1'b0;
   logic          start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;

   // a: defaults, b: SEED=0, c: SEED=0 N=1, d: defaults N=1
   logic [31:0] data_a, data_b, data_c, data_d;
   logic        vld_a, vld_b, vld_c, vld_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic [7:0]  cnt_a, cnt_b, cnt_c, cnt_d;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   output_capture_misr u_a (
      .clk(clk), .rst(rst), .start(start_a), .y(y), .y_valid(y_valid),
      .sig_data(data_a), .sig_valid(vld_a), .sig_ready(sig_ready),
      .busy(busy_a), .sample_count(cnt_a));

   output_capture_misr #(.SEED(32'h0)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .y(y), .y_valid(y_valid),
      .sig_data(data_b), .sig_valid(vld_b), .sig_ready(sig_ready),
      .busy(busy_b), .sample_count(cnt_b));

   output_capture_misr #(.SEED(32'h0), .NUM_SAMPLES(1)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .y(y), .y_valid(y_valid),
      .sig_data(data_c), .sig_valid(vld_c), .sig_ready(sig_ready),
      .busy(busy_c), .sample_count(cnt_c));

   output_capture_misr #(.NUM_SAMPLES(1)) u_d (
      .clk(clk), .rst(rst), .start(start_d), .y(y), .y_valid(y_valid),
      .sig_data(data_d), .sig_valid(vld_d), .sig_ready(sig_ready),
      .busy(busy_d), .sample_count(cnt_d));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: each y bit i lands on signature bit i mod 32.
   function automatic logic [31:0] ref_step(input logic [31:0] m, input logic [YW-1:0] v);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < YW; i++)
         if (v[i]) f[i % 32] = ~f[i % 32];
      return {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ f;
   endfunction

   function automatic logic [YW-1:0] rand_y();
      logic [639:0] t;
      for (int w = 0; w < 20; w++) t[w*32 +: 32] = $urandom;
      return t[YW-1:0];
   endfunction

   typedef struct {
      bit          use_d;
      logic [YW-1:0] y;
      logic [31:0] exp;
   } vec_t;

   vec_t            tbl[8];
   logic [YW-1:0]   vecs[22];
   logic [31:0]     exp_sig;

   // One-sample run on instance c or d, then handshake back to IDLE.
   task automatic run_one(input int idx, input vec_t v);
      logic [31:0] d;
      logic        vl, bz;
      logic [7:0]  c;
      if (v.use_d) start_d = 1'b1; else start_c = 1'b1;
      step();
      start_c = 1'b0; start_d = 1'b0;
      y = v.y; y_valid = 1'b1;
      step();
      y_valid = 1'b0; y = '0;
      d  = v.use_d ? data_d : data_c;
      vl = v.use_d ? vld_d  : vld_c;
      c  = v.use_d ? cnt_d  : cnt_c;
      chk($sformatf("vec%0d_valid", idx), 64'(vl), 64'd1);
      chk($sformatf("vec%0d_data", idx), 64'(d), 64'(v.exp));
      chk($sformatf("vec%0d_count", idx), 64'(c), 64'd1);
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;
      vl = v.use_d ? vld_d  : vld_c;
      bz = v.use_d ? busy_d : busy_c;
      chk($sformatf("vec%0d_idle", idx), 64'({bz, vl}), 64'd0);
   endtask

   // Gap-free 22-sample run on instance a; leaves it in DONE.
   task automatic run_a_clean();
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int k = 0; k < 22; k++) begin
         y = vecs[k]; y_valid = 1'b1;
         step();
      end
      y_valid = 1'b0; y = '0;
   endtask

   initial begin
      logic [YW-1:0] yb;
      int k, cyc;

      yb = '0;
      tbl[0] = '{0, yb, 32'h00000000};
      yb = '0; yb[0] = 1'b1;
      tbl[1] = '{0, yb, 32'h00000001};
      yb = '0; yb[634] = 1'b1;
      tbl[2] = '{0, yb, 32'h04000000};
      yb = '0; yb[32] = 1'b1;
      tbl[3] = '{0, yb, 32'h00000001};
      yb = '0; yb[1] = 1'b1; yb[33] = 1'b1;
      tbl[4] = '{0, yb, 32'h00000000};
      yb = '1;
      tbl[5] = '{0, yb, 32'hF8000000};
      yb = '0;
      tbl[6] = '{1, yb, 32'hFB3EE249};
      yb = '0; yb[0] = 1'b1;
      tbl[7] = '{1, yb, 32'hFB3EE248};

      for (int i = 0; i < 22; i++) vecs[i] = rand_y();
      exp_sig = SEED;
      for (int i = 0; i < 22; i++) exp_sig = ref_step(exp_sig, vecs[i]);

      // Reset state
      #2;
      chk("rst_data", 64'(data_a), 64'd0);
      chk("rst_flags", 64'({vld_a, busy_a}), 64'd0);
      chk("rst_count", 64'(cnt_a), 64'd0);
      step(); step();
      rst = 1'b0;
      step();

      // y_valid in IDLE is ignored
      y = rand_y(); y_valid = 1'b1;
      step();
      y_valid = 1'b0;
      chk("idle_ignore", 64'({busy_a, cnt_a}), 64'd0);

      for (int i = 0; i < 8; i++) run_one(i, tbl[i]);

      // Baseline: SEED=0, zero samples
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      y = '0; y_valid = 1'b1;
      for (int i = 0; i < 21; i++) step();
      chk("base_early_valid", 64'(vld_b), 64'd0);
      chk("base_count21", 64'(cnt_b), 64'd21);
      step();
      y_valid = 1'b0;
      chk("base_valid", 64'(vld_b), 64'd1);
      chk("base_data", 64'(data_b), 64'd0);
      chk("base_count22", 64'(cnt_b), 64'd22);
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;
      chk("base_idle", 64'({busy_b, vld_b}), 64'd0);

      // Gap-free run with backpressure and start in DONE
      run_a_clean();
      chk("clean_data", 64'(data_a), 64'(exp_sig));
      for (int i = 0; i < 5; i++) begin
         start_a = (i == 2);
         y_valid = 1'b1; y = rand_y();
         step();
         chk($sformatf("bp%0d_hold", i), 64'({vld_a, busy_a, data_a}), {30'd0, 2'b11, exp_sig});
      end
      start_a = 1'b1; sig_ready = 1'b1; y_valid = 1'b0;
      step();
      sig_ready = 1'b0; start_a = 1'b0;
      chk("bp_handshake", 64'({vld_a, busy_a}), 64'd0);
      chk("bp_retain", 64'(data_a), 64'(exp_sig));
      step();
      chk("bp_start_ignored", 64'(busy_a), 64'd0);

      // Gapped run, junk on y during gaps, sig_ready already high
      sig_ready = 1'b1;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      k = 0; cyc = 0;
      while (k < 22 && cyc < 200) begin
         if ($urandom_range(0, 2) == 0) begin
            y = rand_y(); y_valid = 1'b0;
         end else begin
            y = vecs[k]; y_valid = 1'b1; k++;
         end
         step();
         cyc++;
         if (k < 22) chk($sformatf("gap_count_c%0d", cyc), 64'(cnt_a), 64'(k));
      end
      y_valid = 1'b0;
      chk("gap_done_in_budget", 64'(k), 64'd22);
      chk("gap_valid", 64'(vld_a), 64'd1);
      chk("gap_data", 64'(data_a), 64'(exp_sig));
      chk("gap_count", 64'(cnt_a), 64'd22);
      step();
      sig_ready = 1'b0;
      chk("gap_one_cycle_valid", 64'({vld_a, busy_a}), 64'd0);

      // Asynchronous reset mid-run
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         y = vecs[i]; y_valid = 1'b1;
         step();
      end
      y_valid = 1'b0;
      chk("pre_rst_count", 64'(cnt_a), 64'd10);
      #3 rst = 1'b1;
      #1;
      chk("arst_flags", 64'({vld_a, busy_a}), 64'd0);
      chk("arst_count", 64'(cnt_a), 64'd0);
      chk("arst_data", 64'(data_a), 64'd0);
      #2 rst = 1'b0;
      step();
      run_a_clean();
      chk("post_rst_valid", 64'(vld_a), 64'd1);
      chk("post_rst_data", 64'(data_a), 64'(exp_sig));
      sig_ready = 1'b1;
      step();
      sig_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
